// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_pkg
// Brief    : Shared defaults and opcode encodings for the reservation
//            station and its entry slice.
// Revision : 1.0 - initial release
// ============================================================================
package reservation_station_pkg;

    // Default widths used by the reservation station parameter lists
    localparam int c_TAG_WIDTH_DEF  = 8;
    localparam int c_DATA_WIDTH_DEF = 128;
    localparam int c_OP_WIDTH_DEF   = 6;
    localparam int c_DEPTH_DEF      = 4;
    localparam int c_REG_ADDR_WIDTH = 4;

    // Opcode encodings carried through to the execution unit
    localparam logic [5:0] c_OP_NOP = 6'd0;
    localparam logic [5:0] c_OP_ADD = 6'd1;
    localparam logic [5:0] c_OP_SUB = 6'd2;
    localparam logic [5:0] c_OP_MUL = 6'd3;

endpackage : reservation_station_pkg
`default_nettype wire

// File: rtl/rs_entry.sv
`default_nettype none
// ============================================================================
// Module   : rs_entry
// Brief    : One reservation-station slot: op storage, result-bus snoop and
//            capture for pending sources, alloc-time broadcast forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module rs_entry
    import reservation_station_pkg::*;
#(
    parameter int OP_WIDTH   = c_OP_WIDTH_DEF,
    parameter int TAG_WIDTH  = c_TAG_WIDTH_DEF,
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_alloc_en,
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic [TAG_WIDTH-1:0]  i_dtag,
    input  logic                  i_src0_rdy,
    input  logic [TAG_WIDTH-1:0]  i_src0_tag,
    input  logic [DATA_WIDTH-1:0] i_src0_data,
    input  logic                  i_src1_rdy,
    input  logic [TAG_WIDTH-1:0]  i_src1_tag,
    input  logic [DATA_WIDTH-1:0] i_src1_data,
    input  logic                  i_bcast,
    input  logic [TAG_WIDTH-1:0]  i_bcast_tag,
    input  logic [DATA_WIDTH-1:0] i_bcast_data,
    input  logic                  i_free_en,
    output logic                  o_valid,
    output logic [OP_WIDTH-1:0]   o_op,
    output logic [TAG_WIDTH-1:0]  o_dtag,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic                  o_ready
);

    logic                  r_valid;
    logic [OP_WIDTH-1:0]   r_op;
    logic [TAG_WIDTH-1:0]  r_dtag;
    logic                  r_rdy0;
    logic                  r_rdy1;
    logic [TAG_WIDTH-1:0]  r_tag0;
    logic [TAG_WIDTH-1:0]  r_tag1;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;

    // A source arriving with the same edge's broadcast is taken straight
    // off the bus, otherwise the result would be missed entirely.
    logic w_fwd0;
    logic w_fwd1;
    logic w_cap0;
    logic w_cap1;

    assign w_fwd0 = !i_src0_rdy && i_bcast && (i_src0_tag == i_bcast_tag);
    assign w_fwd1 = !i_src1_rdy && i_bcast && (i_src1_tag == i_bcast_tag);
    assign w_cap0 = r_valid && !r_rdy0 && i_bcast && (r_tag0 == i_bcast_tag);
    assign w_cap1 = r_valid && !r_rdy1 && i_bcast && (r_tag1 == i_bcast_tag);

    // Slot storage: alloc write, free on issue, capture from result bus
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_dtag  <= '0;
            r_rdy0  <= 1'b0;
            r_rdy1  <= 1'b0;
            r_tag0  <= '0;
            r_tag1  <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_dtag  <= '0;
            r_rdy0  <= 1'b0;
            r_rdy1  <= 1'b0;
            r_tag0  <= '0;
            r_tag1  <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else if (i_alloc_en) begin
            r_valid <= 1'b1;
            r_op    <= i_op;
            r_dtag  <= i_dtag;
            r_rdy0  <= i_src0_rdy || w_fwd0;
            r_rdy1  <= i_src1_rdy || w_fwd1;
            r_tag0  <= i_src0_tag;
            r_tag1  <= i_src1_tag;
            r_data0 <= w_fwd0 ? i_bcast_data : i_src0_data;
            r_data1 <= w_fwd1 ? i_bcast_data : i_src1_data;
        end else begin
            if (i_free_en) begin
                r_valid <= 1'b0;
            end
            if (w_cap0) begin
                r_rdy0  <= 1'b1;
                r_data0 <= i_bcast_data;
            end
            if (w_cap1) begin
                r_rdy1  <= 1'b1;
                r_data1 <= i_bcast_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_op    = r_op;
    assign o_dtag  = r_dtag;
    assign o_data0 = r_data0;
    assign o_data1 = r_data1;
    assign o_ready = r_valid && r_rdy0 && r_rdy1;

endmodule : rs_entry
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Brief    : Operand-capture issue queue. Holds renamed ops until both
//            sources are available, then dispatches one op at a time through
//            a single output register with a valid/ready handshake.
//            Build option RS_OLDEST_FIRST_EN: age-matrix oldest-ready issue
//            selection (default: lowest-index ready entry).
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int TAG_WIDTH  = c_TAG_WIDTH_DEF,
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int DEPTH      = c_DEPTH_DEF,
    parameter int OP_WIDTH   = c_OP_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [OP_WIDTH-1:0]        alloc_op,
    input  logic [TAG_WIDTH-1:0]       alloc_tag,
    input  logic                       src0_rdy,
    input  logic [TAG_WIDTH-1:0]       src0_tag,
    input  logic [DATA_WIDTH-1:0]      src0_data,
    input  logic                       src1_rdy,
    input  logic [TAG_WIDTH-1:0]       src1_tag,
    input  logic [DATA_WIDTH-1:0]      src1_data,
    input  logic                       bcast_IN,
    input  logic [TAG_WIDTH-1:0]       bcast_tag_IN,
    input  logic [DATA_WIDTH-1:0]      d_IN,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [OP_WIDTH-1:0]        issue_op,
    output logic [TAG_WIDTH-1:0]       issue_tag,
    output logic [DATA_WIDTH-1:0]      issue_a,
    output logic [DATA_WIDTH-1:0]      issue_b,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_ready;
    logic [DEPTH-1:0]      w_alloc_en;
    logic [DEPTH-1:0]      w_free_en;
    logic [OP_WIDTH-1:0]   w_op    [DEPTH];
    logic [TAG_WIDTH-1:0]  w_dtag  [DEPTH];
    logic [DATA_WIDTH-1:0] w_data0 [DEPTH];
    logic [DATA_WIDTH-1:0] w_data1 [DEPTH];

    logic [c_IDX_W-1:0]    w_alloc_idx;
    logic                  w_alloc_fire;
    logic [c_IDX_W-1:0]    w_sel_idx;
    logic                  w_sel_valid;
    logic                  w_issue_load;
    logic [c_CNT_W-1:0]    w_count;

    logic                  r_issue_valid;
    logic [OP_WIDTH-1:0]   r_issue_op;
    logic [TAG_WIDTH-1:0]  r_issue_tag;
    logic [DATA_WIDTH-1:0] r_issue_a;
    logic [DATA_WIDTH-1:0] r_issue_b;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_alloc_en[gi] = w_alloc_fire && (w_alloc_idx == c_IDX_W'(gi));
            assign w_free_en[gi]  = w_issue_load && w_sel_valid && (w_sel_idx == c_IDX_W'(gi));

            rs_entry #(
                .OP_WIDTH   (OP_WIDTH),
                .TAG_WIDTH  (TAG_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_entry (
                .clk          (clk),
                .i_rst_n      (rst),
                .i_flush      (flush),
                .i_alloc_en   (w_alloc_en[gi]),
                .i_op         (alloc_op),
                .i_dtag       (alloc_tag),
                .i_src0_rdy   (src0_rdy),
                .i_src0_tag   (src0_tag),
                .i_src0_data  (src0_data),
                .i_src1_rdy   (src1_rdy),
                .i_src1_tag   (src1_tag),
                .i_src1_data  (src1_data),
                .i_bcast      (bcast_IN),
                .i_bcast_tag  (bcast_tag_IN),
                .i_bcast_data (d_IN),
                .i_free_en    (w_free_en[gi]),
                .o_valid      (w_valid[gi]),
                .o_op         (w_op[gi]),
                .o_dtag       (w_dtag[gi]),
                .o_data0      (w_data0[gi]),
                .o_data1      (w_data1[gi]),
                .o_ready      (w_ready[gi])
            );
        end
    endgenerate

    // Lowest-index free slot; readiness comes from registered state only
    always_comb begin
        w_alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_alloc_idx = c_IDX_W'(i);
            end
        end
    end

    assign alloc_ready  = !(&w_valid);
    assign w_alloc_fire = alloc_valid && alloc_ready;
    assign w_issue_load = !r_issue_valid || issue_ready;
    assign w_sel_valid  = |w_ready;

`ifdef RS_OLDEST_FIRST_EN
    // r_age[i][j] = 1 means entry i was allocated before entry j
    logic [DEPTH-1:0] r_age [DEPTH];

    // New entry is younger than every other slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else if (w_alloc_fire) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_age[w_alloc_idx][j] <= 1'b0;
                r_age[j][w_alloc_idx] <= (j != int'(w_alloc_idx));
            end
        end
    end

    // Pick the ready entry that no other ready entry is older than
    always_comb begin
        logic w_older;
        w_sel_idx = '0;
        w_older   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_older = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (w_ready[j] && r_age[j][i]) begin
                    w_older = 1'b1;
                end
            end
            if (w_ready[i] && !w_older) begin
                w_sel_idx = c_IDX_W'(i);
            end
        end
    end
`else
    // Pick the lowest-index ready entry
    always_comb begin
        w_sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_idx = c_IDX_W'(i);
            end
        end
    end
`endif

    // Issue register: refills whenever empty or being drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_tag   <= '0;
            r_issue_a     <= '0;
            r_issue_b     <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_tag   <= '0;
            r_issue_a     <= '0;
            r_issue_b     <= '0;
        end else if (w_issue_load) begin
            r_issue_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_issue_op  <= w_op[w_sel_idx];
                r_issue_tag <= w_dtag[w_sel_idx];
                r_issue_a   <= w_data0[w_sel_idx];
                r_issue_b   <= w_data1[w_sel_idx];
            end
        end
    end

    // Occupancy is the population count of valid slots
    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + c_CNT_W'(w_valid[i]);
        end
    end

    assign count       = w_count;
    assign issue_valid = r_issue_valid;
    assign issue_op    = r_issue_op;
    assign issue_tag   = r_issue_tag;
    assign issue_a     = r_issue_a;
    assign issue_b     = r_issue_b;

endmodule : reservation_station
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Brief    : Directed self-checking bench for reservation_station.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [5:0]   alloc_op;
    logic [7:0]   alloc_tag;
    logic         src0_rdy;
    logic [7:0]   src0_tag;
    logic [127:0] src0_data;
    logic         src1_rdy;
    logic [7:0]   src1_tag;
    logic [127:0] src1_data;
    logic         bcast_IN;
    logic [7:0]   bcast_tag_IN;
    logic [127:0] d_IN;
    logic         issue_valid;
    logic         issue_ready;
    logic [5:0]   issue_op;
    logic [7:0]   issue_tag;
    logic [127:0] issue_a;
    logic [127:0] issue_b;
    logic [2:0]   count;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] first_tag;
    logic [7:0] second_tag;

    reservation_station #(
        .TAG_WIDTH  (8),
        .DATA_WIDTH (128),
        .DEPTH      (4),
        .OP_WIDTH   (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_op     (alloc_op),
        .alloc_tag    (alloc_tag),
        .src0_rdy     (src0_rdy),
        .src0_tag     (src0_tag),
        .src0_data    (src0_data),
        .src1_rdy     (src1_rdy),
        .src1_tag     (src1_tag),
        .src1_data    (src1_data),
        .bcast_IN     (bcast_IN),
        .bcast_tag_IN (bcast_tag_IN),
        .d_IN         (d_IN),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_op     (issue_op),
        .issue_tag    (issue_tag),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One rising edge, then return at the falling edge for drive/sample
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alloc(input logic [5:0] op, input logic [7:0] dtag,
                         input logic r0, input logic [7:0] t0, input logic [127:0] d0,
                         input logic r1, input logic [7:0] t1, input logic [127:0] d1);
        alloc_valid = 1'b1;
        alloc_op    = op;
        alloc_tag   = dtag;
        src0_rdy    = r0;
        src0_tag    = t0;
        src0_data   = d0;
        src1_rdy    = r1;
        src1_tag    = t1;
        src1_data   = d1;
    endtask

    task automatic bc(input logic v, input logic [7:0] t, input logic [127:0] d);
        bcast_IN     = v;
        bcast_tag_IN = t;
        d_IN         = d;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; issue_ready = 1'b1;
        alloc_valid = 1'b0; alloc_op = '0; alloc_tag = '0;
        src0_rdy = 1'b0; src0_tag = '0; src0_data = '0;
        src1_rdy = 1'b0; src1_tag = '0; src1_data = '0;
        bc(1'b0, 8'h00, 128'h0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_issue_tag", issue_tag, 0);
        chk("rst_issue_a", issue_a, 0);
        rst = 1'b1;

        // 1: both sources ready, two-edge alloc-to-issue
        alloc(6'd3, 8'h11, 1, 8'h00, 128'd5, 1, 8'h00, 128'd7);
        tick();
        alloc_valid = 1'b0;
        chk("t1_count_e1", count, 1);
        chk("t1_valid_e1", issue_valid, 0);
        tick();
        chk("t1_valid_e2", issue_valid, 1);
        chk("t1_op", issue_op, 3);
        chk("t1_tag", issue_tag, 8'h11);
        chk("t1_a", issue_a, 5);
        chk("t1_b", issue_b, 7);
        chk("t1_count_e2", count, 0);
        tick();
        chk("t1_drain", issue_valid, 0);

        // 2: pending src0 woken by broadcast three cycles later
        alloc(6'd1, 8'h21, 0, 8'h20, 128'd0, 1, 8'h00, 128'd2);
        tick();
        alloc_valid = 1'b0;
        tick();
        tick();
        chk("t2_wait_valid", issue_valid, 0);
        chk("t2_wait_count", count, 1);
        bc(1'b1, 8'h20, 128'hAB);
        tick();
        bc(1'b0, 8'h00, 128'h0);
        chk("t2_capture_edge", issue_valid, 0);
        tick();
        chk("t2_valid", issue_valid, 1);
        chk("t2_tag", issue_tag, 8'h21);
        chk("t2_a", issue_a, 128'hAB);
        chk("t2_b", issue_b, 2);
        tick();
        chk("t2_count", count, 0);

        // 3: broadcast on the same edge as the alloc is forwarded
        alloc(6'd2, 8'h31, 1, 8'h00, 128'd4, 0, 8'h30, 128'd0);
        bc(1'b1, 8'h30, 128'h99);
        tick();
        alloc_valid = 1'b0;
        bc(1'b0, 8'h00, 128'h0);
        chk("t3_count", count, 1);
        tick();
        chk("t3_valid", issue_valid, 1);
        chk("t3_tag", issue_tag, 8'h31);
        chk("t3_a", issue_a, 4);
        chk("t3_b", issue_b, 128'h99);
        tick();

        // 4: fill all four slots, fifth alloc is ignored
        for (int i = 0; i < 4; i++) begin
            alloc(6'd1, 8'h40 + 8'(i), 0, 8'h50 + 8'(i), 128'd0, 1, 8'h00, 128'h100 + 128'(i));
            tick();
        end
        alloc(6'd1, 8'h44, 1, 8'h00, 128'hEE, 1, 8'h00, 128'hEE);
        chk("t4_full_ready", alloc_ready, 0);
        chk("t4_full_count", count, 4);
        tick();
        alloc_valid = 1'b0;
        chk("t4_ignored_count", count, 4);
        chk("t4_ignored_valid", issue_valid, 0);
        bc(1'b1, 8'h52, 128'h77);
        tick();
        bc(1'b0, 8'h00, 128'h0);
        chk("t4_cap_ready", alloc_ready, 0);
        tick();
        chk("t4_issue_valid", issue_valid, 1);
        chk("t4_issue_tag", issue_tag, 8'h42);
        chk("t4_issue_a", issue_a, 128'h77);
        chk("t4_issue_b", issue_b, 128'h102);
        chk("t4_count", count, 3);
        chk("t4_alloc_ready", alloc_ready, 1);

        // 5: back-pressure holds the issue register for five edges
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      bc(1'b1, 8'h50, 128'h10);
            else if (k == 1) bc(1'b1, 8'h51, 128'h11);
            else             bc(1'b0, 8'h00, 128'h0);
            tick();
            chk("t5_hold_valid", issue_valid, 1);
            chk("t5_hold_tag", issue_tag, 8'h42);
            chk("t5_hold_a", issue_a, 128'h77);
        end
        chk("t5_hold_count", count, 3);
        issue_ready = 1'b1;
        tick();
        chk("t5_next_tag", issue_tag, 8'h40);
        chk("t5_next_a", issue_a, 128'h10);
        chk("t5_next_count", count, 2);
        tick();
        chk("t5_last_tag", issue_tag, 8'h41);
        chk("t5_last_a", issue_a, 128'h11);
        chk("t5_last_count", count, 1);
        tick();
        chk("t5_empty_valid", issue_valid, 0);
        chk("t5_empty_count", count, 1);

        // 6: flush with three entries and a held issue register
        alloc(6'd1, 8'h60, 0, 8'h70, 128'd0, 1, 8'h00, 128'd0);
        tick();
        alloc(6'd1, 8'h61, 0, 8'h71, 128'd0, 1, 8'h00, 128'd0);
        tick();
        alloc(6'd1, 8'h62, 1, 8'h00, 128'h33, 1, 8'h00, 128'h44);
        tick();
        alloc_valid = 1'b0;
        issue_ready = 1'b0;
        chk("t6_pre_count", count, 4);
        tick();
        chk("t6_pre_valid", issue_valid, 1);
        chk("t6_pre_tag", issue_tag, 8'h62);
        chk("t6_pre_count3", count, 3);
        flush = 1'b1;
        issue_ready = 1'b1;
        alloc(6'd1, 8'h63, 1, 8'h00, 128'd1, 1, 8'h00, 128'd1);
        bc(1'b1, 8'h53, 128'd1);
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        bc(1'b0, 8'h00, 128'h0);
        chk("t6_count", count, 0);
        chk("t6_valid", issue_valid, 0);
        chk("t6_tag", issue_tag, 0);
        chk("t6_alloc_ready", alloc_ready, 1);
        tick();
        chk("t6_after_count", count, 0);
        chk("t6_after_valid", issue_valid, 0);

        // 7: slot 2 older than re-used slot 0, both woken together
        alloc(6'd1, 8'h90, 0, 8'h80, 128'd0, 1, 8'h00, 128'd0);
        tick();
        alloc(6'd1, 8'h91, 0, 8'h81, 128'd0, 1, 8'h00, 128'd0);
        tick();
        alloc(6'd1, 8'h92, 0, 8'h82, 128'd0, 1, 8'h00, 128'd0);
        tick();
        alloc_valid = 1'b0;
        bc(1'b1, 8'h80, 128'hA0);
        tick();
        bc(1'b0, 8'h00, 128'h0);
        tick();
        chk("t7_first_tag", issue_tag, 8'h90);
        chk("t7_first_a", issue_a, 128'hA0);
        alloc(6'd1, 8'h93, 0, 8'h82, 128'd0, 1, 8'h00, 128'd0);
        tick();
        alloc_valid = 1'b0;
        chk("t7_gap_valid", issue_valid, 0);
        chk("t7_gap_count", count, 3);
        bc(1'b1, 8'h82, 128'hC2);
        tick();
        bc(1'b0, 8'h00, 128'h0);
`ifdef RS_OLDEST_FIRST_EN
        first_tag  = 8'h92;
        second_tag = 8'h93;
`else
        first_tag  = 8'h93;
        second_tag = 8'h92;
`endif
        tick();
        chk("t7_pick1_tag", issue_tag, first_tag);
        chk("t7_pick1_a", issue_a, 128'hC2);
        tick();
        chk("t7_pick2_tag", issue_tag, second_tag);
        chk("t7_pick2_a", issue_a, 128'hC2);
        chk("t7_count", count, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_reservation_station
`default_nettype wire
